reg_cmd_parser: RTL

- Upstream command front-end for the three-register write bank.
- Parses a received byte stream into write frames: sync, address, data, and optional checksum.
- Drives the bank's write strobe (my_wr), one-hot register selects and 8-bit data bus.
- Rejects malformed or stalled frames and counts errors.

---
 rtl/reg_cmd_pkg.sv | 28 ++
 rtl/frame_timer.sv | 36 +++
 rtl/reg_cmd_parser.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/reg_cmd_pkg.sv
// Shared types and constants for the register-bank command parser.
// REG_CMD_CHECKSUM_EN adds the checksum state to the frame FSM.
package reg_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [7:0] ADDR_REG1         = 8'h01;
    localparam logic [7:0] ADDR_REG2         = 8'h02;
    localparam logic [7:0] ADDR_REG3         = 8'h03;

`ifdef REG_CMD_CHECKSUM_EN
    typedef enum logic [1:0] {StIdle, StAddr, StData, StCsum} state_e;
`else
    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;
`endif

    // One-hot {reg3, reg2, reg1} select; zero for an unmapped address.
    function automatic logic [2:0] addr_to_sel(input logic [7:0] addr);
        logic [2:0] sel;
        case (addr)
            ADDR_REG1: sel = 3'b001;
            ADDR_REG2: sel = 3'b010;
            ADDR_REG3: sel = 3'b100;
            default:   sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte watchdog: counts stalled cycles and pulses expire when the
// count would reach TIMEOUT. A clear in the same cycle always wins.
module frame_timer #(
    parameter int unsigned      TMO_W   = 16,
    parameter logic [TMO_W-1:0] TIMEOUT = TMO_W'(1000)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TMO_W-1:0] LAST = TIMEOUT - TMO_W'(1);

    logic [TMO_W-1:0] count_q, count_d;

    always_comb begin
        expire  = enable && !clear && (count_q == LAST);
        count_d = count_q;
        if (clear || expire) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reg_cmd_parser.sv
// Byte-stream front-end for the three-register write bank: sync/addr/data
// frames (plus checksum byte when REG_CMD_CHECKSUM_EN is defined).
module reg_cmd_parser
    import reg_cmd_pkg::*;
#(
    parameter logic [7:0]       SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int unsigned      TMO_W     = 16,
    parameter logic [TMO_W-1:0] TIMEOUT   = TMO_W'(1000)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       my_wr,
    output logic       cs_reg1,
    output logic       cs_reg2,
    output logic       cs_reg3,
    output logic [7:0] data,
    output logic       busy,
    output logic       frame_err,
    output logic [7:0] err_count
);

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic       my_wr_q, my_wr_d;
    logic [2:0] cs_q, cs_d;
    logic [7:0] data_q, data_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] err_count_q, err_count_d;
`ifdef REG_CMD_CHECKSUM_EN
    logic [7:0] pend_q, pend_d;
`endif

    logic       frame_done;
    logic       frame_ok;
    logic [7:0] frame_byte;
    logic [2:0] sel;
    logic       err_event;
    logic       tmr_enable;
    logic       tmr_expire;

    assign tmr_enable = (state_q != StIdle) && !rx_valid;

    frame_timer #(
        .TMO_W   (TMO_W),
        .TIMEOUT (TIMEOUT)
    ) u_frame_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_valid),
        .enable (tmr_enable),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        my_wr_d     = 1'b0;
        cs_d        = 3'b000;
        data_d      = data_q;
        frame_err_d = 1'b0;
        err_count_d = err_count_q;
        frame_done  = 1'b0;
        frame_ok    = 1'b0;
        frame_byte  = 8'h00;
        err_event   = 1'b0;
        sel         = addr_to_sel(addr_q);
`ifdef REG_CMD_CHECKSUM_EN
        pend_d      = pend_q;
`endif

        case (state_q)
            StIdle: begin
                if (rx_valid && (rx_byte == SYNC_BYTE)) begin
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (rx_valid) begin
                    addr_d  = rx_byte;
                    state_d = StData;
                end
            end
            StData: begin
                if (rx_valid) begin
`ifdef REG_CMD_CHECKSUM_EN
                    pend_d  = rx_byte;
                    state_d = StCsum;
`else
                    frame_done = 1'b1;
                    frame_ok   = 1'b1;
                    frame_byte = rx_byte;
                    state_d    = StIdle;
`endif
                end
            end
`ifdef REG_CMD_CHECKSUM_EN
            StCsum: begin
                if (rx_valid) begin
                    frame_done = 1'b1;
                    frame_ok   = (rx_byte == (SYNC_BYTE ^ addr_q ^ pend_q));
                    frame_byte = pend_q;
                    state_d    = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Expiry only fires without rx_valid, so it never overlaps frame_done.
        if (tmr_expire) begin
            state_d   = StIdle;
            err_event = 1'b1;
        end

        if (frame_done) begin
            if (frame_ok && (sel != 3'b000)) begin
                my_wr_d = 1'b1;
                cs_d    = sel;
                data_d  = frame_byte;
            end else begin
                err_event = 1'b1;
            end
        end

        if (err_event) begin
            frame_err_d = 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            addr_q      <= 8'h00;
            my_wr_q     <= 1'b0;
            cs_q        <= 3'b000;
            data_q      <= 8'h00;
            frame_err_q <= 1'b0;
            err_count_q <= 8'h00;
`ifdef REG_CMD_CHECKSUM_EN
            pend_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            my_wr_q     <= my_wr_d;
            cs_q        <= cs_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
`ifdef REG_CMD_CHECKSUM_EN
            pend_q      <= pend_d;
`endif
        end
    end

    assign my_wr     = my_wr_q;
    assign cs_reg1   = cs_q[0];
    assign cs_reg2   = cs_q[1];
    assign cs_reg3   = cs_q[2];
    assign data      = data_q;
    assign busy      = (state_q != StIdle);
    assign frame_err = frame_err_q;
    assign err_count = err_count_q;

endmodule
